fixed_divider_seq: RTL and testbench

- Iterative signed Q16.16 fixed-point divider; the inverse operation of the team's combinational Q16.16 multiplier.
- Computes q = (a << 16) / b, truncated toward zero.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Valid/ready on both input and output; sits beside the multiplier in the DCT/quantisation datapath, where it serves division by quantisation steps and normalisation.

---
 rtl/fixed_divider_seq.sv | 144 ++++++++++++++
 tb/tb_fixed_divider_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fixed_divider_seq.sv
// Iterative signed Q16.16 divider: restoring shift-subtract, one quotient bit per clock.
// Optional macro FIXED_DIV_SAT_EN saturates div_res on overflow instead of wrapping.
`timescale 1ns/1ps
module fixed_divider_seq #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] div_res,
    output logic              div_by_zero,
    output logic              overflow
);
    localparam int QW = DATA_W + FRAC_W;
    localparam int CW = $clog2(QW);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [QW-1:0]     MAG_LIM = {{FRAC_W{1'b0}}, MIN_NEG};

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic                a_neg_q, a_neg_d;
    logic [DATA_W-1:0]   bmag_q, bmag_d;
    logic [QW-1:0]       num_q, num_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [QW-1:0]       quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                dbz_q, dbz_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   a_abs, b_abs, res_wrap;
    logic [DATA_W+1:0]   rem_wide;
    logic                rem_ge, ovf_fin;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        a_neg_d  = a_neg_q;
        bmag_d   = bmag_q;
        num_d    = num_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        a_abs    = a[DATA_W-1] ? -a : a;
        b_abs    = b[DATA_W-1] ? -b : b;
        rem_wide = {rem_q, num_q[cnt_q]};
        rem_ge   = rem_wide >= {2'b00, bmag_q};
        res_wrap = DATA_W'(sign_q ? -quo_q : quo_q);
        ovf_fin  = sign_q ? (quo_q > MAG_LIM) : (quo_q >= MAG_LIM);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = a[DATA_W-1] ^ b[DATA_W-1];
                    a_neg_d = a[DATA_W-1];
                    bmag_d  = b_abs;
                    num_d   = {a_abs, {FRAC_W{1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(QW - 1);
                    dbz_d   = (b == '0);
                    ovf_d   = 1'b0;
                    // Zero divisor still passes through FINISH so its result registers there.
                    state_d = (b == '0) ? FINISH : CALC;
                end
            end
            CALC: begin
                rem_d = (DATA_W+1)'(rem_ge ? rem_wide - {2'b00, bmag_q} : rem_wide);
                quo_d = {quo_q[QW-2:0], rem_ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = FINISH;
            end
            FINISH: begin
                if (dbz_q) begin
                    res_d = a_neg_q ? MIN_NEG : MAX_POS;
                    ovf_d = 1'b0;
                end else begin
                    ovf_d = ovf_fin;
`ifdef FIXED_DIV_SAT_EN
                    res_d = ovf_fin ? (sign_q ? MIN_NEG : MAX_POS) : res_wrap;
`else
                    res_d = res_wrap;
`endif
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            a_neg_q <= 1'b0;
            bmag_q  <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            a_neg_q <= a_neg_d;
            bmag_q  <= bmag_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign div_res     = res_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_divider_seq.sv
// Directed bench for fixed_divider_seq: hand-computed Q16.16 quotients, latency, backpressure, reset.
`timescale 1ns/1ps
module tb_fixed_divider_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, overflow;
    logic [31:0] a, b, div_res;
    int          n_total = 0;
    int          n_pass  = 0;

`ifdef FIXED_DIV_SAT_EN
    localparam logic [31:0] OVF_BIG_RES = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_MIN_RES = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_BIG_RES = 32'hFF00_0000;
    localparam logic [31:0] OVF_MIN_RES = 32'h8000_0000;
`endif

    always #5 clk = ~clk;

    fixed_divider_seq #(.DATA_W(32), .FRAC_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_res     (div_res),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int w = 0;
        while (!in_ready && w < 100) begin
            step;
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            step;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_res, input logic exp_dbz, input logic exp_ovf,
                          input int exp_lat);
        int lat;
        start_op(tag, av, bv);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, div_res, exp_res);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step;
        step;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", div_res, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        step;

        run_op("p3_div_2",     32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49);
        run_op("m1_div_4",     32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 1'b0, 1'b0, 49);
        run_op("p1_div_3",     32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
        run_op("m1_div_3",     32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 49);
        run_op("ovf_big",      32'h7FFF_0000, 32'h0000_0100, OVF_BIG_RES,   1'b0, 1'b1, 49);
        run_op("dbz_pos",      32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run_op("dbz_neg",      32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
        run_op("min_div_1",    32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49);
        run_op("min_div_m1",   32'h8000_0000, 32'hFFFF_0000, OVF_MIN_RES,   1'b0, 1'b1, 49);
        run_op("neg_zero",     32'hFFFF_FFFF, 32'h7FFF_0000, 32'h0000_0000, 1'b0, 1'b0, 49);

        // Backpressure: result held, new operands ignored while out_ready stays low.
        start_op("bp", 32'h0003_0000, 32'h0002_0000);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd49);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'h0001_0000;
            b        = 32'h0000_0000;
            step;
            check("bp_hold_res", div_res, 32'h0001_8000);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_busy", 32'(in_ready), 32'd0);
            check("bp_hold_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        check("bp_release_ov", 32'(out_valid), 32'd0);
        step;
        check("bp_still_idle", 32'(in_ready), 32'd1);

        // Reset partway through CALC abandons the transaction.
        start_op("mid_rst", 32'h0007_0000, 32'h0002_0000);
        repeat (20) step;
        check("mid_rst_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_res", div_res, 32'd0);
        run_op("after_rst", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
